ram_bytewide_clr: RTL and testbench
===================================

# ram_bytewide_clr

Parametrised single-port synchronous RAM, DATA_BYTES bytes wide and 2^ADDR_WIDTH words deep, with per-byte write enables, a read-valid strobe and a built-in clear sequencer that zeroes every location after reset or on request. It is the general-purpose successor to the fixed 16K x 8 byte RAM. It serves as program/data memory and scratch buffers in the subsystem, where software must see deterministic zeroed contents after reset.

## Interface
Parameters:
- DATA_BYTES, default 4: word width in bytes; data width is 8*DATA_BYTES.
- ADDR_WIDTH, default 12: word address width; DEPTH = 2^ADDR_WIDTH.

Ports:
- CLK  in  1  sole clock; all state changes on its rising edge.
- RST  in  1  reset, synchronous, active-high; one clock, synchronous active-high reset.
- EN  in  1  access request; ignored while RDY=0.
- WE  in  DATA_BYTES  per-byte write enable; WE[i] selects DI/mem byte i (bits 8i+7:8i).
- ADDR  in  ADDR_WIDTH  word address.
- DI  in  8*DATA_BYTES  write data.
- CLR  in  1  clear request; sampled only in IDLE.
- DO  out  8*DATA_BYTES  read data; holds its value between reads.
- VALID  out  1  one-cycle strobe: DO carries data for an accepted read.
- RDY  out  1  high in IDLE; accesses accepted only when high.

## Operation
- States: CLEAR, IDLE. Counter clr_addr, ADDR_WIDTH bits.
- RST=1: state<=CLEAR, clr_addr<=0, DO<=0, VALID<=0, RDY<=0. All pipeline registers clear.
- CLEAR:
  - Each cycle writes all-zero to mem[clr_addr] and increments clr_addr.
  - When clr_addr = DEPTH-1 is written, the next state is IDLE and clr_addr wraps to 0.
  - EN, WE and CLR are ignored.
- IDLE, EN=1, WE=0 (read): DO<=mem[ADDR]; VALID pulses.
- IDLE, EN=1, WE!=0 (write):
  - Bytes with WE[i]=1 are updated; other bytes keep their value.
  - DO is unchanged and VALID stays 0.
  - No read-modify-write is needed; this is a native byte-enable write.
- IDLE, EN=0: no memory access; DO holds its value and VALID=0.
- IDLE, CLR=1: next state is CLEAR with clr_addr=0.
  - If EN=1 in the same cycle, the access is performed first, then clearing starts.
- RDY = (state==IDLE) and (not the cycle in which CLR was accepted); it is registered.
- RST asserted mid-clear restarts the clear from address 0. Contents already written are irrelevant because all are rezeroed.

## Timing
- Read latency 1 cycle without RAM_OUTREG_EN: DO and VALID are valid on the edge after the EN cycle.
- Back-to-back reads sustain one per cycle.
- Read of an address written in the previous cycle returns the new data. A read and a write are never in the same cycle (single port).
- Clear duration: exactly DEPTH cycles. RDY rises on the edge DEPTH cycles after the first edge with RST=0 (or after CLR acceptance).
- CLR accepted in cycle t: RDY=0 from t+1 through t+DEPTH; RDY=1 at t+DEPTH+1.
- Any access issued while RDY=0 is dropped: no write, no VALID.
- With RAM_OUTREG_EN, a read in flight when CLR is accepted still delivers VALID at its normal latency.

## Configuration
- RAM_OUTREG_EN defined:
  - Adds an output register stage; DO/VALID latency becomes 2 cycles.
  - The extra stage resets to DO=0, VALID=0.
  - Throughput is still one read per cycle.
- RAM_OUTREG_EN undefined: latency 1, as described above.

## Test plan
- Reset and clear, DATA_BYTES=4, ADDR_WIDTH=4: release RST -> RDY=0 for 16 cycles, then 1. Read all 16 addresses -> every DO=0x00000000 with VALID.
- Byte-enable write: write 0xAABBCCDD to addr 3 with WE=4'b1111, then 0x11223344 with WE=4'b0101 -> read addr 3 returns 0xAA22CC44 at latency 1 (2 with RAM_OUTREG_EN).
- Back-to-back: write addr 5 = 0x12345678, next cycle read addr 5 -> DO=0x12345678. Reads of addr 0..7 on consecutive cycles -> 8 consecutive VALID pulses with matching data.
- CLR with EN: write addr 2 = 0xDEADBEEF with CLR=1 in the same cycle -> RDY low 16 cycles. Then read addr 2 -> 0x00000000.
- Dropped access and reset mid-clear: EN/WE=4'hF to addr 1 while RDY=0 -> no effect. Assert RST at clear cycle 7 -> clear restarts, RDY rises 16 cycles after RST release, addr 1 reads 0.

Source files
------------

// File: rtl/ram_bytewide_clr.sv
// rtl/ram_bytewide_clr.sv - byte-enable single-port RAM with clear sequencer (optional RAM_OUTREG_EN output stage)
module ram_bytewide_clr #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    EN,
  input  logic [DATA_BYTES-1:0]   WE,
  input  logic [ADDR_WIDTH-1:0]   ADDR,
  input  logic [8*DATA_BYTES-1:0] DI,
  input  logic                    CLR,
  output logic [8*DATA_BYTES-1:0] DO,
  output logic                    VALID,
  output logic                    RDY
);

  localparam int DW    = 8 * DATA_BYTES;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] clr_addr, clr_addr_next;
  logic                  rd, wr;
  logic [DW-1:0]         mem [DEPTH];
  logic [DW-1:0]         rd_data;
  logic                  rd_valid;

  // Next-state logic: sweep every address in CLEAR, leave IDLE on a clear request
  always_comb begin
    state_next    = state;
    clr_addr_next = clr_addr;
    rd            = 1'b0;
    wr            = 1'b0;
    case (state)
      CLEAR: begin
        clr_addr_next = clr_addr + 1'b1;
        if (&clr_addr) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        rd = EN && (WE == '0);
        wr = EN && (WE != '0);
        if (CLR) begin
          state_next    = CLEAR;
          clr_addr_next = '0;
        end
      end
      default: begin
        state_next    = CLEAR;
        clr_addr_next = '0;
      end
    endcase
  end

  // State, clear counter and registered ready (low in the cycle after CLR is taken)
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= CLEAR;
      clr_addr <= '0;
      RDY      <= 1'b0;
    end else begin
      state    <= state_next;
      clr_addr <= clr_addr_next;
      RDY      <= (state_next == IDLE);
    end
  end

  // Memory array: clear sweep has priority, otherwise native byte-enable writes
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state == CLEAR) begin
        mem[clr_addr] <= '0;
      end else if (wr) begin
        for (int i = 0; i < DATA_BYTES; i++) begin
          if (WE[i]) begin
            mem[ADDR][8*i +: 8] <= DI[8*i +: 8];
          end
        end
      end
    end
  end

  // First read stage: data holds between reads, valid is a one-cycle strobe
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd;
      if (rd) begin
        rd_data <= mem[ADDR];
      end
    end
  end

`ifdef RAM_OUTREG_EN
  logic [DW-1:0] out_data;
  logic          out_valid;

  // Extra output stage; in-flight reads complete regardless of clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= rd_valid;
      if (rd_valid) begin
        out_data <= rd_data;
      end
    end
  end

  assign DO    = out_data;
  assign VALID = out_valid;
`else
  assign DO    = rd_data;
  assign VALID = rd_valid;
`endif

endmodule

// File: tb/tb_ram_bytewide_clr.sv
// tb/tb_ram_bytewide_clr.sv - scoreboard testbench for ram_bytewide_clr
module tb_ram_bytewide_clr;

  localparam int DB  = 4;
  localparam int AW  = 4;
  localparam int DEP = 1 << AW;
`ifdef RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          EN  = 1'b0;
  logic [DB-1:0] WE  = '0;
  logic [AW-1:0] ADDR = '0;
  logic [31:0]   DI  = '0;
  logic          CLR = 1'b0;
  logic [31:0]   DO;
  logic          VALID;
  logic          RDY;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [DEP];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  ram_bytewide_clr #(.DATA_BYTES(DB), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .WE(WE), .ADDR(ADDR), .DI(DI),
    .CLR(CLR), .DO(DO), .VALID(VALID), .RDY(RDY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: every VALID must match the oldest outstanding read
  always @(negedge CLK) begin
    if (VALID && !RST) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rd_data", DO, e.data);
        check("rd_latency", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    EN = 1'b0; WE = '0; CLR = 1'b0; DI = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEP; i++) model[i] = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [DB-1:0] we);
    EN = 1'b1; WE = we; ADDR = a; DI = d;
    for (int i = 0; i < DB; i++) if (we[i]) model[a][8*i +: 8] = d[8*i +: 8];
    tick();
    idle();
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    exp_t e;
    EN = 1'b1; WE = '0; ADDR = a;
    e.data = model[a];
    e.cyc  = cyc + LAT;
    sb.push_back(e);
    tick();
  endtask

  task automatic drain();
    int n;
    idle();
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("drain", sb.size(), 0);
    tick();
  endtask

  // Count cycles with RDY low; optionally issue accesses that must be dropped
  task automatic wait_rdy(input string tag, input bit drop);
    int n;
    n = 0;
    while (!RDY && n < 100) begin
      n++;
      if (drop && n >= 5 && n <= 8) begin
        EN = 1'b1; WE = '1; ADDR = 4'd1; DI = 32'hFFFF_FFFF;
      end else if (drop && n == 9) begin
        EN = 1'b1; WE = '0; ADDR = 4'd1;
      end else begin
        idle();
      end
      tick();
    end
    idle();
    check(tag, n, 16);
  endtask

  initial begin
    model_clear();
    tick();
    tick();
    check("reset_rdy", RDY, 0);
    check("reset_valid", VALID, 0);
    check("reset_do", DO, 0);
    RST = 1'b0;
    wait_rdy("reset_clear_len", 1'b0);

    // Every location reads back zero after the initial clear
    for (int a = 0; a < DEP; a++) do_read(a[AW-1:0]);
    drain();

    // Byte-enable merge
    do_write(4'd3, 32'hAABB_CCDD, 4'b1111);
    do_write(4'd3, 32'h1122_3344, 4'b0101);
    do_read(4'd3);
    drain();
    check("byte_merge_model", model[3], 32'hAA22_CC44);

    // Write then read next cycle, then back-to-back reads
    do_write(4'd5, 32'h1234_5678, 4'b1111);
    do_read(4'd5);
    for (int a = 0; a < 8; a++) do_read(a[AW-1:0]);
    drain();

    // Write with CLR in the same cycle: write lands, then everything is cleared
    EN = 1'b1; WE = 4'hF; ADDR = 4'd2; DI = 32'hDEAD_BEEF; CLR = 1'b1;
    tick();
    idle();
    model_clear();
    wait_rdy("clr_len", 1'b0);
    do_read(4'd2);
    do_read(4'd3);
    drain();

    // Accesses while clearing are dropped, even after the sweep passed the address
    do_write(4'd1, 32'h5555_AAAA, 4'b1111);
    CLR = 1'b1;
    tick();
    idle();
    model_clear();
    wait_rdy("clr_drop_len", 1'b1);
    do_read(4'd1);
    drain();

    // Reset in the middle of a clear restarts the sweep
    do_write(4'd5, 32'h1234_5678, 4'b1111);
    do_read(4'd5);
    drain();
    CLR = 1'b1;
    tick();
    idle();
    model_clear();
    for (int i = 0; i < 6; i++) tick();
    check("midclr_rdy", RDY, 0);
    RST = 1'b1;
    tick();
    check("midclr_reset_do", DO, 0);
    check("midclr_reset_valid", VALID, 0);
    RST = 1'b0;
    wait_rdy("midclr_restart_len", 1'b0);
    do_read(4'd1);
    do_read(4'd5);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
